// File: rtl/aiv_pkg.sv
// Shared AIV video constants and types.
// Used by the framebuffer scheduler and the pixel tracker.
package aiv_pkg;

    localparam int ADDR_W         = 19;
    localparam int ACTIVE_V_START = 23;
    localparam int ACTIVE_LINES   = 288;
    localparam int LINE_WORDS     = 720;
    localparam int LB_AW          = 10;
    localparam int LINE_W         = 9;

    // Prefetch runs one line ahead of the first displayed line.
    localparam int PF_FIRST = ACTIVE_V_START - 1;
    localparam int PF_LAST  = PF_FIRST + ACTIVE_LINES - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_HOST
    } fb_state_e;

    // Word address of the first dot of frame line f, modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] line_base(
        input logic [ADDR_W-1:0] base,
        input logic [9:0]        f,
        input int                words
    );
        logic [31:0] sum;
        sum = 32'(base) + 32'(f) * 32'(words);
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/aiv_sync_edge.sv
// Registered rising-edge detection for hsync and vsync.
// One flop stage per sync; the edge pulse lasts one clock.
module aiv_sync_edge (
    input  logic clk,
    input  logic nReset,
    input  logic hsync_i,
    input  logic vsync_i,
    output logic hs_rise_o,
    output logic vs_rise_o
);

    logic hs_q;
    logic vs_q;

    // Previous-cycle sync levels
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= hsync_i;
            vs_q <= vsync_i;
        end
    end

    assign hs_rise_o = hsync_i & ~hs_q;
    assign vs_rise_o = vsync_i & ~vs_q;

endmodule

// File: rtl/aiv_fb_scheduler.sv
// Framebuffer memory scheduler: line prefetch into a ping-pong
// line buffer, with host writes filling the idle gaps.
module aiv_fb_scheduler #(
    parameter logic [aiv_pkg::ADDR_W-1:0] FB_BASE = 19'h00000,
    parameter int LINE_WORDS = aiv_pkg::LINE_WORDS
) (
    input  logic                        clk,
    input  logic                        nReset,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic                        isFieldOdd,
    input  logic                        host_req,
    input  logic [aiv_pkg::ADDR_W-1:0]  host_addr,
    input  logic [15:0]                 host_wdata,
    output logic                        host_ack,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [aiv_pkg::ADDR_W-1:0]  mem_addr,
    output logic [15:0]                 mem_wdata,
    input  logic                        mem_ack,
    input  logic [15:0]                 mem_rdata,
    output logic                        lb_we,
    output logic [aiv_pkg::LB_AW-1:0]   lb_addr,
    output logic [15:0]                 lb_wdata,
    output logic                        lb_bank,
    output logic                        underrun,
    input  logic                        err_clr
);

    import aiv_pkg::*;

    localparam logic [LB_AW-1:0]  W_LAST  = LB_AW'(LINE_WORDS - 1);
    localparam logic [LINE_W-1:0] L_FIRST = LINE_W'(PF_FIRST);
    localparam logic [LINE_W-1:0] L_LAST  = LINE_W'(PF_LAST);

    fb_state_e          state_q, state_d;
    logic               hs_rise, vs_rise;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [LB_AW-1:0]   w_q, w_d;
    logic               pending_q, pending_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               bank_q, bank_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               lb_we_q, lb_we_d;
    logic [LB_AW-1:0]   lb_addr_q, lb_addr_d;
    logic [15:0]        lb_wdata_q, lb_wdata_d;
    logic               underrun_q, underrun_d;
    logic               trig;
    logic [LINE_W-1:0]  act;
    logic [9:0]         frame;

    aiv_sync_edge u_edge (
        .clk       (clk),
        .nReset    (nReset),
        .hsync_i   (hsync),
        .vsync_i   (vsync),
        .hs_rise_o (hs_rise),
        .vs_rise_o (vs_rise)
    );

    // Field line counter; a vsync edge beats a coincident hsync edge
    always_comb begin
        line_d = line_q;
        if (vs_rise) begin
            line_d = '0;
        end else if (hs_rise) begin
            line_d = line_q + 1'b1;
        end
    end

    assign trig  = hs_rise & ~vs_rise &
                   (line_d >= L_FIRST) & (line_d <= L_LAST);
    assign act   = line_d - L_FIRST;
    assign frame = {act, isFieldOdd};

    // Arbitration, burst sequencing and line-buffer write generation
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        pending_d   = pending_q;
        base_d      = base_q;
        bank_d      = bank_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lb_we_d     = 1'b0;
        lb_addr_d   = lb_addr_q;
        lb_wdata_d  = lb_wdata_q;
        underrun_d  = underrun_q;
        host_ack    = 1'b0;

        if (trig) begin
            pending_d = 1'b1;
            base_d    = line_base(FB_BASE, frame, LINE_WORDS);
            bank_d    = act[0];
        end

        // A trigger mid-burst means the previous line missed its slot
        if (trig && state_q == ST_VID) begin
            underrun_d = 1'b1;
        end else if (err_clr) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pending_d) begin
                    state_d    = ST_VID;
                    pending_d  = 1'b0;
                    w_d        = '0;
                    mem_addr_d = base_d;
                end else if (host_req) begin
                    state_d     = ST_HOST;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                end
            end
            ST_VID: begin
                if (mem_ack) begin
                    lb_we_d    = 1'b1;
                    lb_addr_d  = w_q;
                    lb_wdata_d = mem_rdata;
                    if (pending_d) begin
                        pending_d  = 1'b0;
                        w_d        = '0;
                        mem_addr_d = base_d;
                    end else begin
                        w_d        = w_q + 1'b1;
                        mem_addr_d = mem_addr_q + 1'b1;
                        if (w_q == W_LAST) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_HOST: begin
                if (mem_ack) begin
                    host_ack = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_req_d = (state_d != ST_IDLE);
        mem_we_d  = (state_d == ST_HOST);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            line_q      <= '0;
            w_q         <= '0;
            pending_q   <= 1'b0;
            base_q      <= '0;
            bank_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_wdata_q  <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            w_q         <= w_d;
            pending_q   <= pending_d;
            base_q      <= base_d;
            bank_q      <= bank_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            lb_wdata_q  <= lb_wdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign lb_we     = lb_we_q;
    assign lb_addr   = lb_addr_q;
    assign lb_wdata  = lb_wdata_q;
    assign lb_bank   = bank_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_aiv_fb_scheduler.sv
// Directed bench for aiv_fb_scheduler with a memory model and
// scoreboards for memory accesses and line-buffer writes.
module tb_aiv_fb_scheduler;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        isFieldOdd = 1'b0;
    logic        host_req = 1'b0;
    logic [18:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic        mem_req;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [15:0] lb_wdata;
    logic        lb_bank;
    logic        underrun;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int acks_given = 0;
    int ack_limit = 0;

    logic [35:0] exp_mem[$];
    logic [26:0] exp_lb[$];

    aiv_fb_scheduler dut (
        .clk        (clk),
        .nReset     (nReset),
        .hsync      (hsync),
        .vsync      (vsync),
        .isFieldOdd (isFieldOdd),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata),
        .lb_bank    (lb_bank),
        .underrun   (underrun),
        .err_clr    (err_clr)
    );

    always #6 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_pat(input logic [18:0] a);
        return a[15:0] ^ {a[18:16], 13'h0A5C};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hs_pulse();
        @(negedge clk);
        hsync = 1'b1;
        tick(2);
        hsync = 1'b0;
        tick(2);
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick(2);
    endtask

    // Expected reads base..base+n-1; lb bank switches to bank2 at word sw
    task automatic push_burst(input int base, input int n, input logic bank,
                              input int sw, input logic bank2);
        for (int i = 0; i < n; i++) begin
            logic [18:0] a;
            a = 19'(base + i);
            exp_mem.push_back({1'b0, a, 16'h0000});
            exp_lb.push_back({(i >= sw) ? bank2 : bank, 10'(i), rd_pat(a)});
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_mem.size() != 0 || exp_lb.size() != 0 || mem_req)
               && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 64'(n < 6000), 64'd1);
        tick(2);
    endtask

    task automatic wait_acks(input int k);
        int n;
        n = 0;
        while (acks_given < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", 64'(n < 3000), 64'd1);
    endtask

    task automatic rst_checks(input string tag);
        check({tag, "_mem_req"},   64'(mem_req),   64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_host_ack"},  64'(host_ack),  64'd0);
        check({tag, "_lb_we"},     64'(lb_we),     64'd0);
        check({tag, "_lb_addr"},   64'(lb_addr),   64'd0);
        check({tag, "_lb_wdata"},  64'(lb_wdata),  64'd0);
        check({tag, "_lb_bank"},   64'(lb_bank),   64'd0);
        check({tag, "_underrun"},  64'(underrun),  64'd0);
    endtask

    // Memory model: acks about 3 of 4 cycles, checks each access in order
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (nReset && mem_req &&
                !(ack_limit != 0 && acks_given >= ack_limit) &&
                $urandom_range(0, 3) != 0) begin
                mem_ack = 1'b1;
                mem_rdata = rd_pat(mem_addr);
                acks_given++;
                check("mem_exp_avail", 64'(exp_mem.size() != 0), 64'd1);
                if (exp_mem.size() != 0) begin
                    e = exp_mem.pop_front();
                    check("mem_access",
                          64'({mem_we, mem_addr,
                               mem_we ? mem_wdata : 16'h0000}),
                          64'(e));
                end
                if (mem_we) begin
                    #1;
                    check("host_ack", 64'(host_ack), 64'd1);
                    host_req = 1'b0;
                end
            end
        end
    end

    // Line-buffer write monitor
    initial begin
        logic [26:0] e;
        forever begin
            @(negedge clk);
            if (lb_we === 1'b1) begin
                check("lb_exp_avail", 64'(exp_lb.size() != 0), 64'd1);
                if (exp_lb.size() != 0) begin
                    e = exp_lb.pop_front();
                    check("lb_write", 64'({lb_bank, lb_addr, lb_wdata}),
                          64'(e));
                end
            end
        end
    end

    initial begin
        tick(3);
        rst_checks("rst0");
        @(negedge clk);
        nReset = 1'b1;
        tick(2);

        // Even field, line 22 prefetch of frame line 0
        vs_pulse();
        isFieldOdd = 1'b0;
        repeat (21) hs_pulse();
        check("no_early_req", 64'(mem_req), 64'd0);
        push_burst(0, 720, 1'b0, 720, 1'b0);
        hs_pulse();
        check("bank_even", 64'(lb_bank), 64'd0);
        drain("burst0");

        // Odd field at L=23: frame line 3
        isFieldOdd = 1'b1;
        push_burst(2160, 720, 1'b1, 720, 1'b1);
        hs_pulse();
        check("bank_odd", 64'(lb_bank), 64'd1);
        drain("burst1");

        // Host request and trigger in the same idle cycle
        isFieldOdd = 1'b0;
        push_burst(2880, 720, 1'b0, 720, 1'b0);
        exp_mem.push_back({1'b1, 19'h51234, 16'hC0DE});
        @(negedge clk);
        hsync = 1'b1;
        host_req = 1'b1;
        host_addr = 19'h51234;
        host_wdata = 16'hC0DE;
        tick(2);
        hsync = 1'b0;
        tick(2);
        check("vid_first", 64'({mem_req, mem_we}), 64'd2);
        drain("host_vs_vid");

        // Stall at w=400, next trigger forces underrun and restart
        acks_given = 0;
        ack_limit = 400;
        push_burst(4320, 401, 1'b1, 400, 1'b0);
        hs_pulse();
        wait_acks(400);
        tick(4);
        check("hold_addr", 64'(mem_addr), 64'd4720);
        check("no_underrun_yet", 64'(underrun), 64'd0);
        push_burst(5760, 720, 1'b0, 720, 1'b0);
        hs_pulse();
        check("underrun_set", 64'(underrun), 64'd1);
        check("hold_addr_trig", 64'(mem_addr), 64'd4720);
        ack_limit = 0;
        drain("restart");
        check("underrun_sticky", 64'(underrun), 64'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("underrun_clr", 64'(underrun), 64'd0);

        // Reset mid-burst at w=100
        acks_given = 0;
        ack_limit = 100;
        push_burst(7200, 100, 1'b1, 100, 1'b1);
        hs_pulse();
        wait_acks(100);
        tick(4);
        check("lb_q_before_rst", 64'(exp_lb.size()), 64'd0);
        check("bank_before_rst", 64'(lb_bank), 64'd1);
        nReset = 1'b0;
        #1;
        rst_checks("rst1");
        @(negedge clk);
        nReset = 1'b1;
        ack_limit = 0;
        tick(40);
        check("no_req_after_rst", 64'(mem_req), 64'd0);
        check("mem_q_after_rst", 64'(exp_mem.size()), 64'd0);

        // Coincident vsync/hsync edges: counter clears, no prefetch
        repeat (21) hs_pulse();
        @(negedge clk);
        hsync = 1'b1;
        vsync = 1'b1;
        tick(2);
        hsync = 1'b0;
        vsync = 1'b0;
        tick(6);
        check("no_req_on_both", 64'(mem_req), 64'd0);
        repeat (21) hs_pulse();
        check("still_idle", 64'(mem_req), 64'd0);
        isFieldOdd = 1'b1;
        push_burst(720, 720, 1'b0, 720, 1'b0);
        hs_pulse();
        drain("after_vs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
